// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, keeps one imem request in flight,
// and parks one word while decode stalls. Define FETCH_ALIGN_CHECK_EN for the sticky misaligned-redirect flag.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8002_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        do_branch,
    input  logic [31:0] pc_effective,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] insn,
    output logic        insn_valid
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        drop_q, drop_d;
    logic        req_q, req_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] insn_q, insn_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_insn_q, hold_insn_d;

    logic [31:0] target_s;
    logic        granted_s;

    assign target_s  = {pc_effective[31:2], 2'b00};
    assign granted_s = req_q & imem_gnt;

    // Next-state and datapath selection; a redirect overrides every other path
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_addr_d  = req_addr_q;
        drop_d      = drop_q;
        pc_d        = pc_q;
        insn_d      = insn_q;
        valid_d     = valid_q;
        hold_pc_d   = hold_pc_q;
        hold_insn_d = hold_insn_q;

        if (do_branch) begin
            fetch_pc_d  = target_s;
            valid_d     = 1'b0;
            hold_pc_d   = 32'd0;
            hold_insn_d = 32'd0;
            case (state_q)
                ST_ISSUE: begin
                    // A grant in this cycle leaves a response in flight that must be swallowed
                    if (granted_s) begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_ISSUE;
                end
            endcase
        end else begin
            if (valid_q && !stall) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
            case (state_q)
                ST_ISSUE: begin
                    if (granted_s) begin
                        req_addr_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                        state_d    = ST_WAIT;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (!imem_rvalid) begin
                        state_d = ST_WAIT;
                    end else if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end else if (!stall || !valid_q) begin
                        pc_d    = req_addr_q;
                        insn_d  = imem_rdata;
                        valid_d = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        hold_pc_d   = req_addr_q;
                        hold_insn_d = imem_rdata;
                        state_d     = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        pc_d    = hold_pc_q;
                        insn_d  = hold_insn_q;
                        valid_d = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_ISSUE;
                end
            endcase
        end

        req_d = (state_d == ST_ISSUE);
    end

    // State, PC and presentation registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ISSUE;
            fetch_pc_q  <= RESET_PC;
            req_addr_q  <= RESET_PC;
            drop_q      <= 1'b0;
            req_q       <= 1'b0;
            pc_q        <= 32'd0;
            insn_q      <= 32'd0;
            valid_q     <= 1'b0;
            hold_pc_q   <= 32'd0;
            hold_insn_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            drop_q      <= drop_d;
            req_q       <= req_d;
            pc_q        <= pc_d;
            insn_q      <= insn_d;
            valid_q     <= valid_d;
            hold_pc_q   <= hold_pc_d;
            hold_insn_q <= hold_insn_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = fetch_pc_q;
    assign pc         = pc_q;
    assign insn       = insn_q;
    assign insn_valid = valid_q;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned_q;

    // Sticky record of any redirect whose target had non-zero low bits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_q | (do_branch & (pc_effective[1:0] != 2'b00));
        end
    end

    assign fetch_misaligned = misaligned_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Owns the architectural PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Presents pc/insn/insn_valid to decode.
- Consumes the redirect pair (do_branch, pc_effective) driven by execute. It is the receiving end of the execute-to-fetch redirect interface.
- Keeps at most one memory request outstanding and a one-entry hold buffer for decode stalls.

Parameters:
- RESET_PC, 32'h80020000, PC loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  decode cannot accept; hold current pc/insn
- do_branch  in  1  redirect request from execute
- pc_effective  in  32  redirect target from execute
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch byte address, word aligned
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- pc  out  32  PC of presented instruction
- insn  out  32  presented instruction
- insn_valid  out  1  pc/insn valid to decode

Behaviour:
- Reset (async, reset_n=0):
  - fetch_pc=RESET_PC; state=ISSUE; drop flag cleared.
  - imem_req=0; imem_addr=RESET_PC.
  - pc=0, insn=0, insn_valid=0, hold buffer empty.
- States: ISSUE, WAIT_RSP, HOLD.
- ISSUE:
  - imem_req=1, imem_addr=fetch_pc.
  - gnt=1 -> WAIT_RSP; fetch_pc += PC_STEP (32-bit wrap, 32'hFFFFFFFC -> 0).
  - gnt=0 -> keep imem_req=1; imem_addr stable.
- WAIT_RSP:
  - imem_req=0. Response arrives at least 1 cycle after gnt.
  - On rvalid with drop=0:
    - If !stall or !insn_valid: pc<=requested address, insn<=rdata, insn_valid<=1, go to ISSUE.
    - Else: capture into hold buffer, go to HOLD.
  - On rvalid with drop=1: discard data, clear drop, go to ISSUE.
- HOLD: when stall=0, move hold buffer to outputs (insn_valid=1), go to ISSUE.
- Output retirement: insn_valid with stall=0 and no new data that cycle -> insn_valid<=0 next edge. Outputs are stable while stall=1.
- Redirect (do_branch=1 at an edge) has priority over everything, including stall and a same-cycle rvalid:
  - fetch_pc<=pc_effective with [1:0] forced to 0.
  - insn_valid<=0 and hold buffer flushed.
  - In WAIT_RSP with no rvalid this cycle: set drop=1, stay WAIT_RSP.
  - In WAIT_RSP with rvalid this cycle: discard data, go to ISSUE.
  - In ISSUE with gnt=1 this cycle: the granted request is orphaned; set drop=1, go to WAIT_RSP, do not increment fetch_pc.
  - In ISSUE with gnt=0, or in HOLD: go to ISSUE.
- Throughput: one instruction per 2 cycles with gnt=1 and 1-cycle response latency. Lower throughput is accepted.
- Reset mid-request: all state is cleared and any late rvalid after reset is ignored. The WAIT_RSP state is not entered after reset until a new gnt.

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined:
  - Adds output port fetch_misaligned (1 bit, reset 0).
  - Set sticky when do_branch=1 and pc_effective[1:0]!=0; cleared only by reset.
  - Target is still forced word-aligned.
- Undefined: port absent; misaligned low bits are silently masked.

Test Plan:
- Reset release, memory gnt=1, rvalid 1 cycle later, rdata=addr^32'hA5A5A5A5 -> pc sequence 80020000, 80020004, 80020008 with matching insn; insn_valid pulses each response.
- stall=1 held 5 cycles while a response for 80020004 arrives -> outputs frozen at 80020000; after stall drops, 80020004 is presented next with no lost or duplicated word.
- do_branch=1, pc_effective=80020100 during WAIT_RSP for 80020008 -> 80020008 response dropped; next presented pc=80020100.
- do_branch and imem_rvalid in the same cycle -> data discarded; next imem_addr=pc_effective; insn_valid=0 the following cycle.
- imem_gnt held low 3 cycles -> imem_req=1 and imem_addr stable across all cycles; fetch_pc increments once only.
- With FETCH_ALIGN_CHECK_EN: redirect to 80020102 -> imem_addr=80020100, fetch_misaligned=1 and it stays set until reset_n=0.
